// File: rtl/sel_demux_map_scan_if.sv
// Lookup, result, table-write and sweep signals of the coordinate-to-channel mapper.
// The master side issues lookups and configures the table; the slave side is the mapper.
interface sel_demux_map_scan_if #(
    parameter int COL_W = 3,
    parameter int ROW_W = 3,
    parameter int CH_W  = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [COL_W-1:0] req_col;
    logic [ROW_W-1:0] req_row;

    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;

    logic             cfg_we;
    logic [COL_W-1:0] cfg_col;
    logic [ROW_W-1:0] cfg_row;
    logic [CH_W-1:0]  cfg_ch;

    logic             scan_start;
    logic             scan_done;
    logic             busy;

    modport master (
        output req_valid, req_col, req_row,
        input  req_ready,
        input  out_valid, out_ch, out_col, out_row,
        output out_ready,
        output cfg_we, cfg_col, cfg_row, cfg_ch,
        output scan_start,
        input  scan_done, busy
    );

    modport slave (
        input  req_valid, req_col, req_row,
        output req_ready,
        output out_valid, out_ch, out_col, out_row,
        input  out_ready,
        input  cfg_we, cfg_col, cfg_row, cfg_ch,
        input  scan_start,
        output scan_done, busy
    );
endinterface

// File: rtl/sel_demux_map_scan.sv
// Maps a (column,row) matrix coordinate to a demux channel through a writable lookup table.
// Serves single lookups over valid/ready and can sweep every coordinate in address order.
module sel_demux_map_scan #(
    parameter int COL_W = 3,
    parameter int ROW_W = 3,
    parameter int CH_W  = 3
) (
    input logic                 clk,
    input logic                 rst,
    sel_demux_map_scan_if.slave bus
);
    localparam int AW    = COL_W + ROW_W;
    localparam int DEPTH = 1 << AW;
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] END_ADDR  = CNT_W'(DEPTH);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] init_cnt;
    logic [CNT_W-1:0] scan_addr;
    logic [CH_W-1:0]  map_mem [DEPTH];

    logic             load_ok;
    logic             req_ready_c;
    logic             req_fire;
    logic             scan_load;
    logic             scan_last_taken;
    logic             beat_load;
    logic [AW-1:0]    rd_addr;
    logic             tab_we;
    logic [AW-1:0]    wr_addr;
    logic [CH_W-1:0]  wr_data;

    // Power-up mapping: the top CH_W address bits, i.e. the row for square defaults.
    function automatic logic [CH_W-1:0] default_ch(input logic [AW-1:0] addr);
        return addr[AW-1 -: CH_W];
    endfunction

    always_comb begin
        load_ok         = !bus.out_valid || bus.out_ready;
        req_ready_c     = (state == ST_IDLE) && !bus.scan_start && load_ok;
        req_fire        = bus.req_valid && req_ready_c;
        scan_load       = (state == ST_SCAN) && load_ok && (scan_addr != END_ADDR);
        scan_last_taken = (state == ST_SCAN) && (scan_addr == END_ADDR)
                          && bus.out_valid && bus.out_ready;
        beat_load       = req_fire || scan_load;
        rd_addr         = (state == ST_SCAN) ? scan_addr[AW-1:0] : {bus.req_row, bus.req_col};
    end

    // INIT owns the write port; configuration writes are only taken once the table is seeded.
    always_comb begin
        tab_we  = 1'b0;
        wr_addr = {bus.cfg_row, bus.cfg_col};
        wr_data = bus.cfg_ch;
        if (state == ST_INIT) begin
            tab_we  = !rst;
            wr_addr = init_cnt[AW-1:0];
            wr_data = default_ch(init_cnt[AW-1:0]);
        end else if (bus.cfg_we && !rst) begin
            tab_we  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tab_we) begin
            map_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            scan_addr <= '0;
            bus.scan_done <= 1'b0;
        end else begin
            bus.scan_done <= scan_last_taken;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.scan_start) begin
                        state     <= ST_SCAN;
                        scan_addr <= '0;
                    end
                end
                ST_SCAN: begin
                    if (scan_load) begin
                        scan_addr <= scan_addr + 1'b1;
                    end
                    if (scan_last_taken) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // The table read happens before any same-edge write lands, so a colliding lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_col   <= '0;
            bus.out_row   <= '0;
        end else if (beat_load) begin
            bus.out_valid <= 1'b1;
            bus.out_ch    <= map_mem[rd_addr];
            bus.out_col   <= rd_addr[COL_W-1:0];
            bus.out_row   <= rd_addr[AW-1:COL_W];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_comb begin
        bus.req_ready = req_ready_c;
        bus.busy      = (state == ST_INIT) || (state == ST_SCAN);
    end
endmodule

// File: tb/tb_sel_demux_map_scan.sv
// Scoreboard bench for sel_demux_map_scan: stimulus pushes expected beats, a negedge monitor pops
// and compares every consumed beat, and the main sequence checks reset, busy, handshake and sweep timing.
module tb_sel_demux_map_scan;
    localparam int COL_W = 3;
    localparam int ROW_W = 3;
    localparam int CH_W  = 3;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sel_demux_map_scan_if #(.COL_W(COL_W), .ROW_W(ROW_W), .CH_W(CH_W)) bus ();

    sel_demux_map_scan #(.COL_W(COL_W), .ROW_W(ROW_W), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] exp_q [$];
    logic [2:0] exp_tab [DEPTH];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: a beat is consumed at the next rising edge when valid and ready are both high here.
    always @(negedge clk) begin
        logic [8:0] exp_beat;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_beat: got ch=%0d col=%0d row=%0d, expected no beat",
                         bus.out_ch, bus.out_col, bus.out_row);
            end else begin
                exp_beat = exp_q.pop_front();
                checkOutput("beat{ch,col,row}", 32'({bus.out_ch, bus.out_col, bus.out_row}), 32'(exp_beat));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_defaults();
        for (int i = 0; i < DEPTH; i++) begin
            exp_tab[i] = 3'(i >> 3);
        end
    endtask

    task automatic cfg_write(input logic [2:0] col, input logic [2:0] row, input logic [2:0] ch);
        bus.cfg_we  = 1'b1;
        bus.cfg_col = col;
        bus.cfg_row = row;
        bus.cfg_ch  = ch;
        exp_tab[{row, col}] = ch;
        tick();
        bus.cfg_we  = 1'b0;
    endtask

    // Issues one lookup and holds it until accepted; the expected beat comes from the bench table.
    task automatic applyStimulus(input logic [2:0] col, input logic [2:0] row);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_col   = col;
        bus.req_row   = row;
        exp_q.push_back({exp_tab[{row, col}], col, row});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.req_valid = 1'b0;
        checkOutput("req_accepted", 32'(ok), 32'd1);
    endtask

    // Counts busy cycles after reset release; INIT must take exactly DEPTH cycles with no output.
    task automatic reset_and_init();
        int  n;
        bit  ov_seen;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd1);
        checkOutput("rst_scan_done", 32'(bus.scan_done), 32'd0);
        checkOutput("rst_out_data", 32'({bus.out_ch, bus.out_col, bus.out_row}), 32'd0);
        tick();
        rst = 1'b0;
        n = 0;
        ov_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
            if (bus.out_valid) ov_seen = 1'b1;
            n++;
        end
        checkOutput("init_busy_cycles", 32'(n), 32'd64);
        checkOutput("init_out_valid_seen", 32'(ov_seen), 32'd0);
        checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
        tick();
    endtask

    task automatic run_scan(input bit toggle);
        int done_cnt;
        bit finished;
        bus.scan_start = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_col    = 3'd0;
        bus.req_row    = 3'd0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back({exp_tab[a], 3'(a), 3'(a >> 3)});
        end
        @(negedge clk);
        checkOutput("scan_prio_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.scan_start = 1'b0;
        bus.req_valid  = 1'b0;
        @(negedge clk);
        checkOutput("scan_busy", 32'(bus.busy), 32'd1);
        done_cnt = 0;
        finished = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (toggle) bus.out_ready = ~bus.out_ready;
            @(negedge clk);
            if (bus.scan_done) done_cnt++;
            if (!bus.busy) begin
                finished = 1'b1;
                break;
            end
        end
        tick();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.scan_done) done_cnt++;
            tick();
        end
        checkOutput("scan_finished", 32'(finished), 32'd1);
        checkOutput("scan_done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("scan_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_col    = '0;
        bus.req_row    = '0;
        bus.out_ready  = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_col    = '0;
        bus.cfg_row    = '0;
        bus.cfg_ch     = '0;
        bus.scan_start = 1'b0;
        rst            = 1'b1;
        load_defaults();
        tick();

        reset_and_init();

        // Default mapping is the row; result arrives one cycle after acceptance.
        applyStimulus(3'd5, 3'd6);
        @(negedge clk);
        checkOutput("latency_out_valid", 32'(bus.out_valid), 32'd1);
        tick();

        cfg_write(3'd2, 3'd1, 3'd7);
        applyStimulus(3'd2, 3'd1);

        // Write and lookup of the same entry in one cycle: lookup sees the old value.
        bus.cfg_we    = 1'b1;
        bus.cfg_col   = 3'd2;
        bus.cfg_row   = 3'd1;
        bus.cfg_ch    = 3'd4;
        bus.req_valid = 1'b1;
        bus.req_col   = 3'd2;
        bus.req_row   = 3'd1;
        exp_q.push_back({3'd7, 3'd2, 3'd1});
        exp_tab[10] = 3'd4;
        @(negedge clk);
        checkOutput("collide_req_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.cfg_we    = 1'b0;
        bus.req_valid = 1'b0;
        applyStimulus(3'd2, 3'd1);
        tick();
        tick();

        // Back-pressure: held beat stays stable and new requests are refused.
        bus.out_ready = 1'b0;
        applyStimulus(3'd3, 3'd2);
        bus.req_valid = 1'b1;
        bus.req_col   = 3'd7;
        bus.req_row   = 3'd7;
        exp_q.push_back({exp_tab[63], 3'd7, 3'd7});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("hold_beat", 32'({bus.out_valid, bus.out_ch, bus.out_col, bus.out_row}),
                        32'({1'b1, 3'd2, 3'd3, 3'd2}));
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_req_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();

        run_scan(1'b0);
        run_scan(1'b1);

        // Reset mid-sweep drops the pending beat and restores default entries.
        cfg_write(3'd4, 3'd4, 3'd1);
        bus.scan_start = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back({exp_tab[a], 3'(a), 3'(a >> 3)});
        end
        tick();
        bus.scan_start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1;
        exp_q.delete();
        load_defaults();
        tick();
        @(negedge clk);
        checkOutput("midscan_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midscan_rst_busy", 32'(bus.busy), 32'd1);
        tick();
        reset_and_init();
        applyStimulus(3'd4, 3'd4);
        applyStimulus(3'd2, 3'd1);
        tick();
        tick();
        checkOutput("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
